// File: rtl/lb_bus_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : lb_bus_pkg                                                       |
// | Purpose : Shared encodings for the 68040 local-bus cycle sizer: FSM state  |
// |           type, CPU transfer size codes, Amiga port size codes and the     |
// |           helpers that turn those codes into byte counts.                  |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package lb_bus_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ADDR = 3'd1,
      ST_WAIT = 3'd2,
      ST_ACK  = 3'd3,
      ST_LOAD = 3'd4,
      ST_ERR  = 3'd5
   } state_t;

   // CPU SIZ encodings
   localparam logic [1:0] SIZ_LONG = 2'b00;
   localparam logic [1:0] SIZ_BYTE = 2'b01;
   localparam logic [1:0] SIZ_WORD = 2'b10;
   localparam logic [1:0] SIZ_LINE = 2'b11;

   // Amiga PORTSIZE encodings; the reserved code behaves as a 32-bit port
   localparam logic [1:0] PORT_32   = 2'b00;
   localparam logic [1:0] PORT_8    = 2'b01;
   localparam logic [1:0] PORT_16   = 2'b10;
   localparam logic [1:0] PORT_RSVD = 2'b11;

   // Bytes to move within the current longword for a CPU transfer size.
   function automatic logic [2:0] rem_encode(input logic [1:0] siz);
      logic [2:0] r;
      case (siz)
         SIZ_BYTE: r = 3'd1;
         SIZ_WORD: r = 3'd2;
         SIZ_LONG: r = 3'd4;
         SIZ_LINE: r = 3'd4;
         default:  r = 3'd4;
      endcase
      return r;
   endfunction

   // Byte width of the Amiga port answering the current cycle.
   function automatic logic [2:0] port_bytes(input logic [1:0] ps);
      logic [2:0] w;
      case (ps)
         PORT_8:    w = 3'd1;
         PORT_16:   w = 3'd2;
         PORT_32:   w = 3'd4;
         PORT_RSVD: w = 3'd4;
         default:   w = 3'd4;
      endcase
      return w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/lb_lane_steer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : lb_lane_steer                                                    |
// | Purpose : Combinational byte-lane steering between the latched CPU         |
// |           longword and the Amiga data bus. The Amiga side always carries   |
// |           the current byte on D31:24, so writes rotate left by the byte    |
// |           offset and reads merge incoming bytes back into their lanes.     |
// | Ports   : addr_lo_i  byte offset A[1:0] of the current port cycle          |
// |           rem_i      bytes still owed in this longword (1..4)              |
// |           portsize_i PORTSIZE code sampled with TACKn                      |
// |           wdata_i    latched CPU write longword                            |
// |           rd_bus_i   Amiga read data                                       |
// |           rd_acc_i   read longword assembled so far                        |
// |           nbytes_o   bytes this port cycle transfers                       |
// |           wr_bus_o   rotated write data for the Amiga bus                  |
// |           rd_acc_o   read longword with this cycle's bytes merged in       |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module lb_lane_steer
   import lb_bus_pkg::*;
(
   input  logic [1:0]  addr_lo_i,
   input  logic [2:0]  rem_i,
   input  logic [1:0]  portsize_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rd_bus_i,
   input  logic [31:0] rd_acc_i,
   output logic [2:0]  nbytes_o,
   output logic [31:0] wr_bus_o,
   output logic [31:0] rd_acc_o
);

   logic [2:0] w_width;
   logic [2:0] w_off;
   logic [2:0] w_avail;
   logic [1:0] w_lane;

   // A narrow port can only complete up to its own boundary, so the cycle
   // length is the smaller of what is owed and what fits before that boundary.
   always_comb begin
      w_width = port_bytes(portsize_i);
      case (w_width)
         3'd1:    w_off = 3'd0;
         3'd2:    w_off = {2'b00, addr_lo_i[0]};
         default: w_off = {1'b0, addr_lo_i};
      endcase
      w_avail  = w_width - w_off;
      nbytes_o = (rem_i < w_avail) ? rem_i : w_avail;
   end

   always_comb begin
      case (addr_lo_i)
         2'd0:    wr_bus_o = wdata_i;
         2'd1:    wr_bus_o = {wdata_i[23:0], wdata_i[31:24]};
         2'd2:    wr_bus_o = {wdata_i[15:0], wdata_i[31:16]};
         default: wr_bus_o = {wdata_i[7:0],  wdata_i[31:8]};
      endcase
   end

   // Bus byte i (counting down from D31:24) lands in lane addr_lo_i+i.
   // Lane k occupies bits [31-8k -: 8]; ~k selects that slot for 2-bit k.
   always_comb begin
      rd_acc_o = rd_acc_i;
      w_lane   = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (3'(i) < nbytes_o) begin
            w_lane = addr_lo_i + 2'(i);
            rd_acc_o[{~w_lane, 3'b000} +: 8] = rd_bus_i[{~(2'(i)), 3'b000} +: 8];
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/lb_bus_sizer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : lb_bus_sizer                                                     |
// | Purpose : Splits each 68040 transfer (byte/word/long/line) into Amiga-side |
// |           port cycles sized dynamically by PORTSIZE, with a bus-error      |
// |           watchdog. Drives data and output enables only; tristates live    |
// |           at the top level.                                                |
// | Ports   : CLK40, RESET          clock, synchronous active-high reset       |
// |           TS_CPUn RnW SIZ A_040 D_CPU_I   CPU transfer request             |
// |           D_CPU_O D_CPU_OE TAn TEA_CPUn TBI_CPUn   CPU response            |
// |           TSn A_AMIGA SIZ_AMIGA RnW_AMIGA D_AMIGA_O D_AMIGA_OE  Amiga out  |
// |           TACKn PORTSIZE D_AMIGA_I   Amiga response                        |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module lb_bus_sizer
   import lb_bus_pkg::*;
#(
   parameter int TIMEOUT_CYC = 255,
   parameter int LINE_BURST  = 1,
   parameter int TMO_W       = 8
) (
   input  logic        CLK40,
   input  logic        RESET,
   input  logic        TS_CPUn,
   input  logic        RnW,
   input  logic [1:0]  SIZ,
   input  logic [3:0]  A_040,
   input  logic [31:0] D_CPU_I,
   output logic [31:0] D_CPU_O,
   output logic        D_CPU_OE,
   output logic        TAn,
   output logic        TEA_CPUn,
   output logic        TBI_CPUn,
   output logic        TSn,
   output logic [3:0]  A_AMIGA,
   output logic [1:0]  SIZ_AMIGA,
   output logic        RnW_AMIGA,
   input  logic        TACKn,
   input  logic [1:0]  PORTSIZE,
   input  logic [31:0] D_AMIGA_I,
   output logic [31:0] D_AMIGA_O,
   output logic        D_AMIGA_OE
);

   localparam bit               c_line_refuse = (LINE_BURST == 0);
   localparam bit               c_tmo_en      = (TIMEOUT_CYC > 0);
   localparam logic [TMO_W-1:0] c_tmo_last    = c_tmo_en ? TMO_W'(TIMEOUT_CYC - 1) : '0;

   state_t            state_q, state_d;
   logic [3:0]        addr_q,  addr_d;
   logic [2:0]        rem_q,   rem_d;
   logic [1:0]        beat_q,  beat_d;
   logic              line_q,  line_d;
   logic              tbi_q,   tbi_d;
   logic              rnw_q,   rnw_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [TMO_W-1:0]  tmo_q,   tmo_d;

   logic [2:0]        w_n;
   logic [31:0]       w_wr_rot;
   logic [31:0]       w_rd_merged;
   logic              w_tmo_hit;

   lb_lane_steer u_steer (
      .addr_lo_i  (addr_q[1:0]),
      .rem_i      (rem_q),
      .portsize_i (PORTSIZE),
      .wdata_i    (wdata_q),
      .rd_bus_i   (D_AMIGA_I),
      .rd_acc_i   (rdata_q),
      .nbytes_o   (w_n),
      .wr_bus_o   (w_wr_rot),
      .rd_acc_o   (w_rd_merged)
   );

   // Counter holds 0..TIMEOUT_CYC-1 while waiting; hitting the last value
   // without TACKn means TIMEOUT_CYC clocks have elapsed since WAIT entry.
   assign w_tmo_hit = c_tmo_en && (tmo_q == c_tmo_last);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge CLK40) begin
      if (RESET) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (!TS_CPUn) begin
               if ((SIZ == SIZ_LINE) && c_line_refuse) state_d = ST_ACK;
               else                                    state_d = ST_ADDR;
            end
         end
         ST_ADDR: state_d = ST_WAIT;
         ST_WAIT: begin
            if (!TACKn)          state_d = (rem_q == w_n) ? ST_ACK : ST_ADDR;
            else if (w_tmo_hit)  state_d = ST_ERR;
         end
         ST_ACK: begin
            if (line_q && !tbi_q && (beat_q != 2'd3)) state_d = ST_LOAD;
            else                                      state_d = ST_IDLE;
         end
         ST_LOAD: state_d = ST_ADDR;
         ST_ERR:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      TSn        = (state_q != ST_ADDR);
      TAn        = (state_q != ST_ACK);
      TEA_CPUn   = (state_q != ST_ERR);
      TBI_CPUn   = !((state_q == ST_ACK) && tbi_q);
      D_CPU_O    = rdata_q;
      D_CPU_OE   = (state_q == ST_ACK) && rnw_q;
      A_AMIGA    = addr_q;
      SIZ_AMIGA  = rem_q[1:0];   // 4 encodes as 00
      RnW_AMIGA  = rnw_q;
      D_AMIGA_O  = w_wr_rot;
      D_AMIGA_OE = ((state_q == ST_ADDR) || (state_q == ST_WAIT)) && !rnw_q;
   end

   // ---------------- datapath next state ----------------
   always_comb begin
      addr_d  = addr_q;
      rem_d   = rem_q;
      beat_d  = beat_q;
      line_d  = line_q;
      tbi_d   = tbi_q;
      rnw_d   = rnw_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      tmo_d   = tmo_q;
      case (state_q)
         ST_IDLE: begin
            if (!TS_CPUn) begin
               addr_d  = A_040;
               rem_d   = rem_encode(SIZ);
               beat_d  = 2'd0;
               line_d  = (SIZ == SIZ_LINE);
               tbi_d   = (SIZ == SIZ_LINE) && c_line_refuse;
               rnw_d   = RnW;
               wdata_d = D_CPU_I;
            end
         end
         ST_ADDR: tmo_d = '0;
         ST_WAIT: begin
            if (!TACKn) begin
               // Offset wraps inside the longword; A[3:2] only moves between beats.
               addr_d[1:0] = addr_q[1:0] + w_n[1:0];
               rem_d       = rem_q - w_n;
               if (rnw_q) rdata_d = w_rd_merged;
            end else if (c_tmo_en) begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         ST_LOAD: begin
            // Critical-longword-first: the line wraps around its 16-byte block.
            beat_d  = beat_q + 2'd1;
            addr_d  = {addr_q[3:2] + 2'd1, 2'b00};
            rem_d   = 3'd4;
            wdata_d = D_CPU_I;
         end
         default: ;
      endcase
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge CLK40) begin
      if (RESET) begin
         addr_q  <= '0;
         rem_q   <= '0;
         beat_q  <= '0;
         line_q  <= 1'b0;
         tbi_q   <= 1'b0;
         rnw_q   <= 1'b1;
         wdata_q <= '0;
         rdata_q <= '0;
         tmo_q   <= '0;
      end else begin
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         beat_q  <= beat_d;
         line_q  <= line_d;
         tbi_q   <= tbi_d;
         rnw_q   <= rnw_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         tmo_q   <= tmo_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_lb_bus_sizer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_lb_bus_sizer                                                  |
// | Purpose : Directed self-checking bench for lb_bus_sizer. A second instance |
// |           built with LINE_BURST=0 covers refused line transfers.           |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_lb_bus_sizer;

   logic        CLK40 = 1'b0;
   logic        RESET, TS_CPUn, TS2_n, RnW, TACKn;
   logic [1:0]  SIZ, PORTSIZE;
   logic [3:0]  A_040;
   logic [31:0] D_CPU_I, D_AMIGA_I;

   logic [31:0] D_CPU_O, D_AMIGA_O;
   logic        D_CPU_OE, TAn, TEA_CPUn, TBI_CPUn, TSn, RnW_AMIGA, D_AMIGA_OE;
   logic [3:0]  A_AMIGA;
   logic [1:0]  SIZ_AMIGA;

   logic [31:0] D_CPU_O2, D_AMIGA_O2;
   logic        D_CPU_OE2, TAn2, TEA2, TBI2, TSn2, RnW_AMIGA2, D_AMIGA_OE2;
   logic [3:0]  A_AMIGA2;
   logic [1:0]  SIZ_AMIGA2;

   always #5 CLK40 = ~CLK40;

   lb_bus_sizer #(.TIMEOUT_CYC(16), .LINE_BURST(1), .TMO_W(8)) dut (
      .CLK40(CLK40), .RESET(RESET), .TS_CPUn(TS_CPUn), .RnW(RnW), .SIZ(SIZ),
      .A_040(A_040), .D_CPU_I(D_CPU_I), .D_CPU_O(D_CPU_O), .D_CPU_OE(D_CPU_OE),
      .TAn(TAn), .TEA_CPUn(TEA_CPUn), .TBI_CPUn(TBI_CPUn), .TSn(TSn),
      .A_AMIGA(A_AMIGA), .SIZ_AMIGA(SIZ_AMIGA), .RnW_AMIGA(RnW_AMIGA),
      .TACKn(TACKn), .PORTSIZE(PORTSIZE), .D_AMIGA_I(D_AMIGA_I),
      .D_AMIGA_O(D_AMIGA_O), .D_AMIGA_OE(D_AMIGA_OE)
   );

   lb_bus_sizer #(.TIMEOUT_CYC(16), .LINE_BURST(0), .TMO_W(8)) dut2 (
      .CLK40(CLK40), .RESET(RESET), .TS_CPUn(TS2_n), .RnW(RnW), .SIZ(SIZ),
      .A_040(A_040), .D_CPU_I(D_CPU_I), .D_CPU_O(D_CPU_O2), .D_CPU_OE(D_CPU_OE2),
      .TAn(TAn2), .TEA_CPUn(TEA2), .TBI_CPUn(TBI2), .TSn(TSn2),
      .A_AMIGA(A_AMIGA2), .SIZ_AMIGA(SIZ_AMIGA2), .RnW_AMIGA(RnW_AMIGA2),
      .TACKn(TACKn), .PORTSIZE(PORTSIZE), .D_AMIGA_I(D_AMIGA_I),
      .D_AMIGA_O(D_AMIGA_O2), .D_AMIGA_OE(D_AMIGA_OE2)
   );

   int n_assert = 0;
   int n_fail   = 0;

   int ts_cnt, ta_cnt, tea_cnt, tbi_cnt, ta_first, tea_first;
   logic [31:0] a_log    [16];
   logic [31:0] siz_log  [16];
   logic [31:0] dao_log  [16];
   logic [31:0] daoe_log [16];
   logic [31:0] rnwa_log [16];
   logic [31:0] dcpu_log [4];
   logic [31:0] dcoe_log [4];
   logic [31:0] rd_tab   [16];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic start(input logic rnw, input logic [1:0] siz, input logic [3:0] a,
                        input logic [31:0] d, input logic [1:0] ps);
      RnW = rnw; SIZ = siz; A_040 = a; D_CPU_I = d; PORTSIZE = ps; TS_CPUn = 1'b0;
   endtask

   // mode 0: never acknowledge, 1: TACKn one clock after each TSn, 2: TACKn held low
   task automatic run(input int mode, input int budget);
      bit prev_ts;
      int idx;
      prev_ts = 1'b0;
      ts_cnt = 0; ta_cnt = 0; tea_cnt = 0; tbi_cnt = 0; ta_first = -1; tea_first = -1;
      for (int c = 0; c < budget; c++) begin
         @(posedge CLK40); #1;
         TS_CPUn = 1'b1;
         if (!TSn) begin
            if (ts_cnt < 16) begin
               a_log[ts_cnt]    = 32'(A_AMIGA);
               siz_log[ts_cnt]  = 32'(SIZ_AMIGA);
               dao_log[ts_cnt]  = D_AMIGA_O;
               daoe_log[ts_cnt] = 32'(D_AMIGA_OE);
               rnwa_log[ts_cnt] = 32'(RnW_AMIGA);
            end
            ts_cnt++;
         end
         if (!TAn) begin
            if (ta_cnt < 4) begin
               dcpu_log[ta_cnt] = D_CPU_O;
               dcoe_log[ta_cnt] = 32'(D_CPU_OE);
            end
            if (ta_first < 0) ta_first = c;
            ta_cnt++;
         end
         if (!TEA_CPUn) begin
            if (tea_first < 0) tea_first = c;
            tea_cnt++;
         end
         if (!TBI_CPUn) tbi_cnt++;
         idx = (ts_cnt > 0) ? ts_cnt - 1 : 0;
         if (idx > 15) idx = 15;
         D_AMIGA_I = rd_tab[idx];
         case (mode)
            1:       TACKn = ~prev_ts;
            2:       TACKn = 1'b0;
            default: TACKn = 1'b1;
         endcase
         prev_ts = !TSn;
      end
      TACKn = 1'b1;
   endtask

   task automatic chk_reset(input string p);
      chk({p, "_TSn"},        32'(TSn),        1);
      chk({p, "_TAn"},        32'(TAn),        1);
      chk({p, "_TEA"},        32'(TEA_CPUn),   1);
      chk({p, "_TBI"},        32'(TBI_CPUn),   1);
      chk({p, "_DCPU_OE"},    32'(D_CPU_OE),   0);
      chk({p, "_DAMIGA_OE"},  32'(D_AMIGA_OE), 0);
      chk({p, "_A_AMIGA"},    32'(A_AMIGA),    0);
      chk({p, "_SIZ_AMIGA"},  32'(SIZ_AMIGA),  0);
      chk({p, "_DCPU_O"},     D_CPU_O,         0);
      chk({p, "_DAMIGA_O"},   D_AMIGA_O,       0);
      chk({p, "_RnW_AMIGA"},  32'(RnW_AMIGA),  1);
   endtask

   initial begin
      int n2ts, n2ta, n2tbi, n2both;
      RESET = 1'b1; TS_CPUn = 1'b1; TS2_n = 1'b1; RnW = 1'b1; TACKn = 1'b1;
      SIZ = 2'b00; PORTSIZE = 2'b00; A_040 = 4'h0; D_CPU_I = '0; D_AMIGA_I = '0;
      for (int i = 0; i < 16; i++) rd_tab[i] = '0;
      repeat (3) @(posedge CLK40);
      #1;
      chk_reset("rst");
      chk("rst2_TAn", 32'(TAn2), 1);
      chk("rst2_TBI", 32'(TBI2), 1);
      chk("rst2_TSn", 32'(TSn2), 1);
      RESET = 1'b0;
      @(posedge CLK40); #1;

      // Long read from an 8-bit port: four byte cycles assembled big-endian.
      rd_tab[0] = 32'h1100_0000; rd_tab[1] = 32'h2200_0000;
      rd_tab[2] = 32'h3300_0000; rd_tab[3] = 32'h4400_0000;
      start(1'b1, 2'b00, 4'h0, 32'h0, 2'b01);
      run(1, 14);
      chk("lr8_tscnt", ts_cnt, 4);
      for (int i = 0; i < 4; i++) chk($sformatf("lr8_addr%0d", i), a_log[i], i);
      chk("lr8_siz0", siz_log[0], 0);
      chk("lr8_siz1", siz_log[1], 3);
      chk("lr8_siz3", siz_log[3], 1);
      chk("lr8_tacnt", ta_cnt, 1);
      chk("lr8_tafirst", ta_first, 8);
      chk("lr8_data", dcpu_log[0], 32'h1122_3344);
      chk("lr8_dcoe", dcoe_log[0], 1);

      // Word write at A=2 to a 16-bit port.
      start(1'b0, 2'b10, 4'h2, 32'h0000_BEEF, 2'b10);
      run(1, 6);
      chk("ww_tscnt", ts_cnt, 1);
      chk("ww_addr", a_log[0], 2);
      chk("ww_siz", siz_log[0], 2);
      chk("ww_dout", dao_log[0], 32'hBEEF_0000);
      chk("ww_doe", daoe_log[0], 1);
      chk("ww_rnw", rnwa_log[0], 0);
      chk("ww_tacnt", ta_cnt, 1);
      chk("ww_dcoe", dcoe_log[0], 0);

      // Line read at A=8 from a 32-bit port: critical longword first.
      rd_tab[0] = 32'h8888_0001; rd_tab[1] = 32'hCCCC_0002;
      rd_tab[2] = 32'h0000_0003; rd_tab[3] = 32'h4444_0004;
      start(1'b1, 2'b11, 4'h8, 32'h0, 2'b00);
      run(1, 22);
      chk("line_tscnt", ts_cnt, 4);
      chk("line_tacnt", ta_cnt, 4);
      chk("line_a0", a_log[0], 8);
      chk("line_a1", a_log[1], 12);
      chk("line_a2", a_log[2], 0);
      chk("line_a3", a_log[3], 4);
      for (int i = 0; i < 4; i++) chk($sformatf("line_d%0d", i), dcpu_log[i], rd_tab[i]);

      // Minimum latency with TACKn held low: early TACKn during TSn is ignored.
      rd_tab[0] = 32'hCAFE_F00D;
      start(1'b1, 2'b00, 4'h4, 32'h0, 2'b00);
      run(2, 6);
      TACKn = 1'b1;
      chk("lat_tafirst", ta_first, 2);
      chk("lat_tscnt", ts_cnt, 1);
      chk("lat_data", dcpu_log[0], 32'hCAFE_F00D);

      // Byte read at A=3: only lane 3 changes.
      rd_tab[0] = 32'h5A00_0000;
      start(1'b1, 2'b01, 4'h3, 32'h0, 2'b00);
      run(1, 6);
      chk("br_siz", siz_log[0], 1);
      chk("br_data", dcpu_log[0], 32'hCAFE_F05A);

      // Word read at A=1 from a 16-bit port crosses a port boundary: two cycles.
      rd_tab[0] = 32'hAB00_0000; rd_tab[1] = 32'hCD00_0000;
      start(1'b1, 2'b10, 4'h1, 32'h0, 2'b10);
      run(1, 8);
      chk("wr16_tscnt", ts_cnt, 2);
      chk("wr16_a1", a_log[1], 2);
      chk("wr16_siz1", siz_log[1], 1);
      chk("wr16_data", dcpu_log[0], 32'hCAAB_CD5A);

      // Long read at A=2 from a 16-bit port: offset wraps to 0 within the longword.
      rd_tab[0] = 32'h3344_0000; rd_tab[1] = 32'h1122_0000;
      start(1'b1, 2'b00, 4'h2, 32'h0, 2'b10);
      run(1, 8);
      chk("lw16_a0", a_log[0], 2);
      chk("lw16_a1", a_log[1], 0);
      chk("lw16_siz1", siz_log[1], 2);
      chk("lw16_data", dcpu_log[0], 32'h1122_3344);

      // Watchdog: WAIT entered at cycle 1, TEA 16 clocks later.
      start(1'b1, 2'b00, 4'h0, 32'h0, 2'b00);
      run(0, 25);
      chk("tmo_teacnt", tea_cnt, 1);
      chk("tmo_teacyc", tea_first, 17);
      chk("tmo_tacnt", ta_cnt, 0);
      chk("tmo_tscnt", ts_cnt, 1);

      // Reset while waiting on the second line beat.
      rd_tab[0] = 32'h1111_1111; rd_tab[1] = 32'h2222_2222;
      start(1'b1, 2'b11, 4'h0, 32'h0, 2'b00);
      run(1, 6);
      chk("rmid_tacnt", ta_cnt, 1);
      chk("rmid_tscnt", ts_cnt, 2);
      RESET = 1'b1; TACKn = 1'b1;
      @(posedge CLK40); #1;
      chk_reset("rmid");
      RESET = 1'b0;
      rd_tab[0] = 32'h600D_F00D;
      start(1'b1, 2'b00, 4'h4, 32'h0, 2'b00);
      run(1, 8);
      chk("post_tscnt", ts_cnt, 1);
      chk("post_tacnt", ta_cnt, 1);
      chk("post_data", dcpu_log[0], 32'h600D_F00D);

      // LINE_BURST=0 instance: line refused with TAn and TBI together, no Amiga cycle.
      RnW = 1'b1; SIZ = 2'b11; A_040 = 4'h0; TS2_n = 1'b0;
      n2ts = 0; n2ta = 0; n2tbi = 0; n2both = 0;
      for (int c = 0; c < 6; c++) begin
         @(posedge CLK40); #1;
         TS2_n = 1'b1;
         if (!TSn2) n2ts++;
         if (!TAn2) n2ta++;
         if (!TBI2) n2tbi++;
         if (!TAn2 && !TBI2 && (c == 0)) n2both++;
      end
      chk("nolb_tscnt", n2ts, 0);
      chk("nolb_tacnt", n2ta, 1);
      chk("nolb_tbicnt", n2tbi, 1);
      chk("nolb_same", n2both, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
